sprite_blitter: RTL and testbench

Parametrised sprite-to-framebuffer drawer for the VGA plot path. It is the general successor of the fixed 5x5 per-direction drawers. It reads one orientation-neutral (right-facing) sprite ROM and produces all four facing directions by address transformation. It emits one pixel per cycle toward the VGA adapter, with transparency keying, screen-edge clipping, and a start/busy/done handshake for the game-control FSM.

---
 rtl/sprite_blitter.sv | 192 +++++++++++++++++++
 tb/tb_sprite_blitter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_blitter.sv
// Sprite-to-framebuffer drawer. Scans a right-facing sprite ROM in raster order,
// remaps the ROM address for the requested facing direction, and emits one pixel
// per cycle with screen-edge clipping and optional transparency keying.
module sprite_blitter #(
  parameter int unsigned SPR_W      = 5,
  parameter int unsigned SPR_H      = 5,
  parameter int unsigned COLOUR_W   = 3,
  parameter int unsigned ROM_LAT    = 1,
  parameter int unsigned SCREEN_W   = 160,
  parameter int unsigned SCREEN_H   = 120,
  parameter bit          TRANSP_EN  = 1'b1,
  parameter int unsigned TRANSP_KEY = 0,
  localparam int unsigned ADDR_W    = $clog2(SPR_W * SPR_H)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [1:0]          dir,
  input  logic [7:0]          startx,
  input  logic [6:0]          starty,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [COLOUR_W-1:0] rom_data,
  output logic [7:0]          x,
  output logic [6:0]          y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                busy,
  output logic                done
);

  localparam int unsigned SX_W   = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int unsigned SY_W   = (SPR_H > 1) ? $clog2(SPR_H) : 1;
  localparam int unsigned DR_W   = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
  // Rotations swap axes, so they only make sense for square sprites.
  localparam bit          SQUARE = (SPR_W == SPR_H);

  typedef enum logic [1:0] {StIdle, StScan, StDrain, StDone} state_e;

  state_e          state_q, state_d;
  logic [SX_W-1:0] sx_q, sx_d;
  logic [SY_W-1:0] sy_q, sy_d;
  logic [DR_W-1:0] drain_q, drain_d;
  logic [1:0]      dir_q, dir_d;
  logic [7:0]      startx_q, startx_d;
  logic [6:0]      starty_q, starty_d;

  logic [ADDR_W-1:0] u, v;
  logic [8:0]        px;
  logic [7:0]        py;
  logic              onscreen;
  logic              transparent;

  // Pixel delay line, aligned with the ROM read latency.
  logic       dl_valid_q [ROM_LAT];
  logic       dl_on_q    [ROM_LAT];
  logic [7:0] dl_x_q     [ROM_LAT];
  logic [6:0] dl_y_q     [ROM_LAT];

  // State, scan counters and latched operands.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= StIdle;
      sx_q     <= '0;
      sy_q     <= '0;
      drain_q  <= '0;
      dir_q    <= '0;
      startx_q <= '0;
      starty_q <= '0;
    end else begin
      state_q  <= state_d;
      sx_q     <= sx_d;
      sy_q     <= sy_d;
      drain_q  <= drain_d;
      dir_q    <= dir_d;
      startx_q <= startx_d;
      starty_q <= starty_d;
    end
  end

  // Next-state logic: raster scan, drain of the ROM pipeline, done pulse.
  always_comb begin
    state_d  = state_q;
    sx_d     = sx_q;
    sy_d     = sy_q;
    drain_d  = drain_q;
    dir_d    = dir_q;
    startx_d = startx_q;
    starty_d = starty_q;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          dir_d    = (SQUARE || !dir[1]) ? dir : 2'd0;
          startx_d = startx;
          starty_d = starty;
          sx_d     = '0;
          sy_d     = '0;
          state_d  = StScan;
        end
      end
      StScan: begin
        busy = 1'b1;
        if (sx_q == SX_W'(SPR_W - 1)) begin
          sx_d = '0;
          if (sy_q == SY_W'(SPR_H - 1)) begin
            sy_d    = '0;
            drain_d = '0;
            state_d = StDrain;
          end else begin
            sy_d = sy_q + 1'b1;
          end
        end else begin
          sx_d = sx_q + 1'b1;
        end
      end
      StDrain: begin
        busy = 1'b1;
        if (drain_q == DR_W'(ROM_LAT - 1)) begin
          state_d = StDone;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Source pixel (u,v) in the right-facing sprite for the current scan position.
  always_comb begin
    u = ADDR_W'(sx_q);
    v = ADDR_W'(sy_q);
    unique case (dir_q)
      2'd1: u = ADDR_W'(SPR_W - 1) - ADDR_W'(sx_q);
      2'd2: begin
        u = ADDR_W'(SPR_W - 1) - ADDR_W'(sy_q);
        v = ADDR_W'(sx_q);
      end
      2'd3: begin
        u = ADDR_W'(sy_q);
        v = ADDR_W'(sx_q);
      end
      default: ;
    endcase
  end

  // ROM address and screen position of the pixel being scanned.
  always_comb begin
    rom_addr = (state_q == StScan) ? (v * ADDR_W'(SPR_W) + u) : '0;
    // One bit wider than the outputs so a sprite past the edge clips, never wraps.
    px       = 9'(startx_q) + 9'(sx_q);
    py       = 8'(starty_q) + 8'(sy_q);
    onscreen = (32'(px) < SCREEN_W) && (32'(py) < SCREEN_H);
  end

  // Carry pixel position alongside the ROM read so it arrives with rom_data.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < ROM_LAT; i++) begin
        dl_valid_q[i] <= 1'b0;
        dl_on_q[i]    <= 1'b0;
        dl_x_q[i]     <= '0;
        dl_y_q[i]     <= '0;
      end
    end else begin
      dl_valid_q[0] <= (state_q == StScan);
      dl_on_q[0]    <= onscreen;
      dl_x_q[0]     <= px[7:0];
      dl_y_q[0]     <= py[6:0];
      for (int i = 1; i < ROM_LAT; i++) begin
        dl_valid_q[i] <= dl_valid_q[i-1];
        dl_on_q[i]    <= dl_on_q[i-1];
        dl_x_q[i]     <= dl_x_q[i-1];
        dl_y_q[i]     <= dl_y_q[i-1];
      end
    end
  end

  // Pixel output toward the VGA adapter.
  always_comb begin
    transparent = TRANSP_EN && (rom_data == COLOUR_W'(TRANSP_KEY));
    x           = dl_x_q[ROM_LAT-1];
    y           = dl_y_q[ROM_LAT-1];
    colour      = rom_data;
    plot        = dl_valid_q[ROM_LAT-1] && dl_on_q[ROM_LAT-1] && !transparent;
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// Bench for sprite_blitter: two instances (ROM_LAT=1 opaque, ROM_LAT=2 keyed) driven
// with the same requests; a pixel-list model predicts every output cycle.
module tb_sprite_blitter;

  localparam int W    = 5;
  localparam int H    = 5;
  localparam int N    = W * H;
  localparam int MAXO = 40;
  localparam int NEVER = 2147483647;

  logic       clock  = 1'b0;
  logic       reset  = 1'b0;
  logic       start  = 1'b0;
  logic [1:0] dir    = '0;
  logic [7:0] startx = '0;
  logic [6:0] starty = '0;

  logic [4:0] addr_a, addr_b;
  logic [2:0] rd_a, rd_b, col_a, col_b;
  logic [7:0] x_a, x_b;
  logic [6:0] y_a, y_b;
  logic       plot_a, plot_b, busy_a, busy_b, done_a, done_b;

  always #5 clock = ~clock;

  sprite_blitter #(
    .SPR_W(W), .SPR_H(H), .COLOUR_W(3), .ROM_LAT(1), .SCREEN_W(160), .SCREEN_H(120),
    .TRANSP_EN(1'b0), .TRANSP_KEY(0)
  ) dut_a (
    .clock(clock), .reset(reset), .start(start), .dir(dir), .startx(startx),
    .starty(starty), .rom_addr(addr_a), .rom_data(rd_a), .x(x_a), .y(y_a),
    .colour(col_a), .plot(plot_a), .busy(busy_a), .done(done_a)
  );

  sprite_blitter #(
    .SPR_W(W), .SPR_H(H), .COLOUR_W(3), .ROM_LAT(2), .SCREEN_W(160), .SCREEN_H(120),
    .TRANSP_EN(1'b1), .TRANSP_KEY(0)
  ) dut_b (
    .clock(clock), .reset(reset), .start(start), .dir(dir), .startx(startx),
    .starty(starty), .rom_addr(addr_b), .rom_data(rd_b), .x(x_b), .y(y_b),
    .colour(col_b), .plot(plot_b), .busy(busy_b), .done(done_b)
  );

  // Sprite ROMs with latency 1 (a) and 2 (b).
  logic [2:0] rom [2][32];
  logic [2:0] pipe_a, pipe_b0, pipe_b1;
  always @(posedge clock) begin
    pipe_a  <= rom[0][addr_a];
    pipe_b0 <= rom[1][addr_b];
    pipe_b1 <= pipe_b0;
  end
  assign rd_a = pipe_a;
  assign rd_b = pipe_b1;

  logic [4:0] o_addr [2];
  logic [2:0] o_col  [2];
  logic [7:0] o_x    [2];
  logic [6:0] o_y    [2];
  logic       o_plot [2];
  logic       o_busy [2];
  logic       o_done [2];
  assign o_addr[0] = addr_a;  assign o_addr[1] = addr_b;
  assign o_col[0]  = col_a;   assign o_col[1]  = col_b;
  assign o_x[0]    = x_a;     assign o_x[1]    = x_b;
  assign o_y[0]    = y_a;     assign o_y[1]    = y_b;
  assign o_plot[0] = plot_a;  assign o_plot[1] = plot_b;
  assign o_busy[0] = busy_a;  assign o_busy[1] = busy_b;
  assign o_done[0] = done_a;  assign o_done[1] = done_b;

  // Model: expected outputs indexed by cycle offset from the start edge.
  int         lat [2] = '{1, 2};
  bit         ten [2] = '{1'b0, 1'b1};
  bit         e_plot [2][MAXO];
  logic [7:0] e_x    [2][MAXO];
  logic [6:0] e_y    [2][MAXO];
  logic [2:0] e_col  [2][MAXO];
  int         e_addr [2][N];

  int cyc       = 0;
  int e0        = -1000;
  int abort_cyc = NEVER;
  int tests     = 0;
  int fails     = 0;

  int obs_plots [2], obs_first_o [2], obs_first_x [2], obs_first_y [2], obs_first_c [2];
  int obs_last_o [2], obs_last_x [2], obs_last_y [2], obs_last_c [2];
  int obs_done_cnt [2], obs_done_o [2], obs_addr0 [2], obs_addr1 [2], obs_hit [2];

  task automatic check(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic build_model(input int dv, input int sx, input int sy);
    for (int d = 0; d < 2; d++) begin
      for (int o = 0; o < MAXO; o++) begin
        e_plot[d][o] = 1'b0;
        e_x[d][o]    = '0;
        e_y[d][o]    = '0;
        e_col[d][o]  = '0;
      end
    end
    for (int k = 0; k < N; k++) begin
      int cx, cy, u, v, a, px, py;
      bit on;
      logic [2:0] c;
      cx = k % W;
      cy = k / W;
      case (dv)
        1:       begin u = W - 1 - cx; v = cy; end
        2:       begin u = W - 1 - cy; v = cx; end
        3:       begin u = cy;         v = cx; end
        default: begin u = cx;         v = cy; end
      endcase
      a  = v * W + u;
      px = sx + cx;
      py = sy + cy;
      on = (px < 160) && (py < 120);
      for (int d = 0; d < 2; d++) begin
        c                      = rom[d][a];
        e_addr[d][k]           = a;
        e_plot[d][k + lat[d]]  = on && !(ten[d] && c == 3'd0);
        e_x[d][k + lat[d]]     = 8'(px);
        e_y[d][k + lat[d]]     = 7'(py);
        e_col[d][k + lat[d]]   = c;
      end
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  task automatic compare_cycle();
    for (int d = 0; d < 2; d++) begin
      int o;
      bit act, ep, eb, ed, ok;
      o   = cyc - e0;
      act = (o >= 0) && (o <= N + lat[d]) && (cyc < abort_cyc);
      ep  = 1'b0;
      eb  = 1'b0;
      ed  = 1'b0;
      if (act) begin
        ep = e_plot[d][o];
        eb = (o < N + lat[d]);
        ed = (o == N + lat[d]);
      end
      ok = (o_plot[d] === ep) && (o_busy[d] === eb) && (o_done[d] === ed);
      if (ep) ok = ok && (o_x[d] === e_x[d][o]) && (o_y[d] === e_y[d][o]) &&
                   (o_col[d] === e_col[d][o]);
      if (act && o < N) ok = ok && (32'(o_addr[d]) === e_addr[d][o]);
      tests++;
      if (!ok) begin
        fails++;
        $display("FAIL cycle dut%0d off=%0d: got plot=%b busy=%b done=%b x=%0d y=%0d col=%0d addr=%0d; want plot=%b busy=%b done=%b x=%0d y=%0d col=%0d addr=%0d",
                 d, o, o_plot[d], o_busy[d], o_done[d], o_x[d], o_y[d], o_col[d], o_addr[d],
                 ep, eb, ed, act ? e_x[d][o] : 8'd0, act ? e_y[d][o] : 7'd0,
                 act ? e_col[d][o] : 3'd0, (act && o < N) ? e_addr[d][o] : 0);
      end
      if (o_plot[d] === 1'b1) begin
        if (obs_plots[d] == 0) begin
          obs_first_o[d] = o;
          obs_first_x[d] = int'(o_x[d]);
          obs_first_y[d] = int'(o_y[d]);
          obs_first_c[d] = int'(o_col[d]);
        end
        obs_last_o[d] = o;
        obs_last_x[d] = int'(o_x[d]);
        obs_last_y[d] = int'(o_y[d]);
        obs_last_c[d] = int'(o_col[d]);
        obs_plots[d]++;
        if (o_x[d] == 8'd12 && o_y[d] == 7'd22) obs_hit[d] = 1;
      end
      if (o_done[d] === 1'b1) begin
        obs_done_cnt[d]++;
        obs_done_o[d] = o;
      end
      if (o == 0) obs_addr0[d] = int'(o_addr[d]);
      if (o == 1) obs_addr1[d] = int'(o_addr[d]);
    end
  endtask

  task automatic step();
    @(negedge clock);
    compare_cycle();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic start_draw(input int dv, input int sx, input int sy);
    dir       = 2'(dv);
    startx    = 8'(sx);
    starty    = 7'(sy);
    start     = 1'b1;
    e0        = cyc + 1;
    abort_cyc = NEVER;
    build_model(dv, sx, sy);
    for (int d = 0; d < 2; d++) begin
      obs_plots[d]    = 0;  obs_first_o[d] = -1; obs_first_x[d] = -1; obs_first_y[d] = -1;
      obs_first_c[d]  = -1; obs_last_o[d]  = -1; obs_last_x[d]  = -1; obs_last_y[d]  = -1;
      obs_last_c[d]   = -1; obs_done_cnt[d] = 0; obs_done_o[d]  = -1; obs_addr0[d]   = -1;
      obs_addr1[d]    = -1; obs_hit[d]     = 0;
    end
    step();
    start = 1'b0;
  endtask

  task automatic directed_rom();
    for (int i = 0; i < 32; i++) begin
      rom[0][i] = 3'(i % 8);
      rom[1][i] = 3'(i % 7 + 1);
    end
    rom[1][12] = 3'd0;
  endtask

  initial begin
    directed_rom();
    run(2);
    check("reset_plot_a", int'(plot_a), 0);
    check("reset_busy_a", int'(busy_a), 0);
    check("reset_done_a", int'(done_a), 0);
    check("reset_addr_a", int'(addr_a), 0);
    check("reset_busy_b", int'(busy_b), 0);
    reset = 1'b1;
    run(2);

    // Basic right-facing draw.
    start_draw(0, 10, 20);
    run(32);
    check("a_plots", obs_plots[0], 25);
    check("a_first_off", obs_first_o[0], 1);
    check("a_first_x", obs_first_x[0], 10);
    check("a_first_y", obs_first_y[0], 20);
    check("a_first_col", obs_first_c[0], 0);
    check("a_last_off", obs_last_o[0], 25);
    check("a_last_x", obs_last_x[0], 14);
    check("a_last_y", obs_last_y[0], 24);
    check("a_last_col", obs_last_c[0], 0);
    check("a_done_off", obs_done_o[0], 26);
    check("a_done_cnt", obs_done_cnt[0], 1);
    check("a_centre_hit", obs_hit[0], 1);
    check("b_plots", obs_plots[1], 24);
    check("b_first_off", obs_first_o[1], 2);
    check("b_last_off", obs_last_o[1], 26);
    check("b_done_off", obs_done_o[1], 27);
    check("b_centre_hit", obs_hit[1], 0);

    // Other facing directions.
    start_draw(1, 10, 20);
    run(32);
    check("dir1_addr1", obs_addr1[0], 3);
    start_draw(2, 10, 20);
    run(32);
    check("dir2_addr0", obs_addr0[0], 4);
    check("dir2_addr1", obs_addr1[0], 9);
    start_draw(3, 10, 20);
    run(32);
    check("dir3_addr1", obs_addr1[0], 5);

    // Bottom-right clipping.
    start_draw(0, 157, 117);
    run(32);
    check("clip_a_plots", obs_plots[0], 9);
    check("clip_a_done_off", obs_done_o[0], 26);
    check("clip_b_plots", obs_plots[1], 8);
    check("clip_b_done_off", obs_done_o[1], 27);

    // Start mid-draw is ignored; reset mid-draw abandons it silently.
    start_draw(0, 10, 20);
    run(3);
    start = 1'b1;
    step();
    start = 1'b0;
    run(4);
    reset     = 1'b0;
    abort_cyc = cyc + 1;
    step();
    check("abort_plot_a", int'(plot_a), 0);
    check("abort_busy_a", int'(busy_a), 0);
    check("abort_busy_b", int'(busy_b), 0);
    check("abort_done_a", int'(done_a), 0);
    step();
    reset = 1'b1;
    run(30);
    check("abort_done_cnt_a", obs_done_cnt[0], 0);
    check("abort_done_cnt_b", obs_done_cnt[1], 0);

    // Fresh draw after the abort.
    start_draw(0, 10, 20);
    run(32);
    check("fresh_a_plots", obs_plots[0], 25);
    check("fresh_a_done_off", obs_done_o[0], 26);

    // Randomized draws and ROM contents.
    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < 32; i++) begin
        rom[0][i] = 3'($urandom_range(0, 7));
        rom[1][i] = 3'($urandom_range(0, 7));
      end
      start_draw(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 127)));
      run(32 + int'($urandom_range(0, 3)));
      check("rand_done_cnt_a", obs_done_cnt[0], 1);
      check("rand_done_cnt_b", obs_done_cnt[1], 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
